// File: rtl/dpc_fetch_pkg.sv
// Shared types and constants for the decimal program counter fetch path.
package dpc_fetch_pkg;
   localparam int unsigned IP_DIGITS_DEFAULT  = 4;
   localparam int unsigned INSN_WIDTH_DEFAULT = 4;

   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD
   } fetch_state_t;
endpackage

// File: rtl/bcd_incrementer.sv
// Combinational N-digit BCD +1; 9..9 wraps to 0..0 with no carry out.
module bcd_incrementer
   import dpc_fetch_pkg::*;
#(
   parameter int unsigned DIGITS = IP_DIGITS_DEFAULT
) (
   input  logic [DIGITS*4-1:0] din,
   output logic [DIGITS*4-1:0] dout
);
   logic [DIGITS-1:0] carry;

   assign carry[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_t d;
      assign d = din[g*4 +: 4];
      assign dout[g*4 +: 4] = !carry[g]              ? d     :
                              (d >= BCD_MAX_DIGIT)   ? 4'd0  :
                                                       d + 4'd1;
      if (g + 1 < DIGITS) begin : g_carry
         assign carry[g+1] = carry[g] & (d >= BCD_MAX_DIGIT);
      end
   end
endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch stage: BCD instruction pointer, ROM req/ack reader, valid/ready output.
// Define INSN_PREFETCH_EN for a one-entry prefetch buffer (one instruction per cycle).
module insn_fetch
   import dpc_fetch_pkg::*;
#(
   parameter int unsigned IP_DIGITS  = IP_DIGITS_DEFAULT,
   parameter int unsigned INSN_WIDTH = INSN_WIDTH_DEFAULT,
   parameter logic [IP_DIGITS*4-1:0] RESET_IP = '0
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Run,
   output logic [IP_DIGITS*4-1:0]  RomAddr,
   output logic                    RomReq,
   input  logic                    RomAck,
   input  logic [INSN_WIDTH-1:0]   RomData,
   output logic [INSN_WIDTH-1:0]   Insn,
   output logic                    InsnValid,
   input  logic                    InsnReady,
   input  logic                    Jump,
   input  logic [IP_DIGITS*4-1:0]  JumpAddr,
   output logic [IP_DIGITS*4-1:0]  Ip,
   output logic                    Halted
);
   localparam int unsigned AW = IP_DIGITS*4;

   fetch_state_t          state_q, state_d;
   logic [AW-1:0]         ip_q, ip_d, ip_inc, jaddr_q, jaddr_d, flush_tgt;
   logic [INSN_WIDTH-1:0] insn_q, insn_d;
   logic                  valid_q, valid_d, flush_q, flush_d;
   logic                  ack, xfer, flush_now;
`ifdef INSN_PREFETCH_EN
   logic [INSN_WIDTH-1:0] pbuf_q, pbuf_d;
   logic                  pvalid_q, pvalid_d, pfout_q, pfout_d;
`endif

   bcd_incrementer #(.DIGITS(IP_DIGITS)) u_inc (.din(ip_q), .dout(ip_inc));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= IDLE;
         ip_q     <= RESET_IP;
         insn_q   <= '0;
         valid_q  <= 1'b0;
         flush_q  <= 1'b0;
         jaddr_q  <= '0;
`ifdef INSN_PREFETCH_EN
         pbuf_q   <= '0;
         pvalid_q <= 1'b0;
         pfout_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ip_q     <= ip_d;
         insn_q   <= insn_d;
         valid_q  <= valid_d;
         flush_q  <= flush_d;
         jaddr_q  <= jaddr_d;
`ifdef INSN_PREFETCH_EN
         pbuf_q   <= pbuf_d;
         pvalid_q <= pvalid_d;
         pfout_q  <= pfout_d;
`endif
      end
   end

   assign ack       = RomReq & RomAck;
   assign xfer      = valid_q & InsnReady;
   // A jump arriving on the acking cycle itself also flushes; the newest target wins.
   assign flush_now = flush_q | Jump;
   assign flush_tgt = Jump ? JumpAddr : jaddr_q;

   always_comb begin
      state_d  = state_q;
      ip_d     = ip_q;
      insn_d   = insn_q;
      valid_d  = valid_q;
      flush_d  = flush_q;
      jaddr_d  = jaddr_q;
`ifdef INSN_PREFETCH_EN
      pbuf_d   = pbuf_q;
      pvalid_d = pvalid_q;
      pfout_d  = pfout_q;
`endif
      case (state_q)
         IDLE: begin
            if (Jump) ip_d = JumpAddr;
            if (Run) state_d = REQ;
         end
         REQ: begin
            if (ack) begin
               flush_d = 1'b0;
               if (flush_now) begin
                  ip_d    = flush_tgt;
                  state_d = Run ? REQ : IDLE;
               end else begin
                  insn_d  = RomData;
                  valid_d = 1'b1;
                  ip_d    = ip_inc;
                  state_d = HOLD;
               end
            end else if (Jump) begin
               flush_d = 1'b1;
               jaddr_d = JumpAddr;
            end
         end
         HOLD: begin
`ifdef INSN_PREFETCH_EN
            if (xfer) begin
               if (Jump) begin
                  valid_d  = 1'b0;
                  pvalid_d = 1'b0;
                  pfout_d  = 1'b0;
                  // An unfinished prefetch keeps its address; its data is dropped in REQ.
                  if (RomReq && !RomAck) begin
                     flush_d = 1'b1;
                     jaddr_d = JumpAddr;
                     state_d = REQ;
                  end else begin
                     ip_d    = JumpAddr;
                     state_d = Run ? REQ : IDLE;
                  end
               end else if (pvalid_q) begin
                  insn_d   = pbuf_q;
                  pvalid_d = 1'b0;
               end else if (ack) begin
                  insn_d  = RomData;
                  ip_d    = ip_inc;
                  pfout_d = 1'b0;
               end else if (RomReq) begin
                  valid_d = 1'b0;
                  pfout_d = 1'b0;
                  state_d = REQ;
               end else begin
                  valid_d = 1'b0;
                  state_d = Run ? REQ : IDLE;
               end
            end else if (ack) begin
               pbuf_d   = RomData;
               pvalid_d = 1'b1;
               ip_d     = ip_inc;
               pfout_d  = 1'b0;
            end else begin
               pfout_d = RomReq;
            end
`else
            if (xfer) begin
               valid_d = 1'b0;
               if (Jump) ip_d = JumpAddr;
               state_d = Run ? REQ : IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      RomReq = (state_q == REQ);
`ifdef INSN_PREFETCH_EN
      if (state_q == HOLD && !pvalid_q && (Run || pfout_q)) RomReq = 1'b1;
`endif
      Halted = (state_q == IDLE);
   end

   assign RomAddr   = ip_q;
   assign Ip        = ip_q;
   assign Insn      = insn_q;
   assign InsnValid = valid_q;
endmodule

// File: tb/tb_insn_fetch.sv
// Self-checking bench for insn_fetch: directed scenarios plus randomized run against a
// transaction-level model of the presented instruction stream (INSN_PREFETCH_EN aware).
module tb_insn_fetch;
   logic        Clk, Rst, Run, RomReq, RomAck, InsnValid, InsnReady, Jump, Halted;
   logic [15:0] RomAddr, JumpAddr, Ip;
   logic [3:0]  RomData, Insn;

   logic [3:0]  rom [0:65535];
   int          n_tests = 0, n_fail = 0, xfers = 0;
   int          exp_ip = 0;
   int          fixed_delay = 0;
   int          age = 0, cur_delay = 0;

   insn_fetch #(.IP_DIGITS(4), .INSN_WIDTH(4), .RESET_IP(16'h0000)) dut (
      .Clk(Clk), .Rst(Rst), .Run(Run), .RomAddr(RomAddr), .RomReq(RomReq),
      .RomAck(RomAck), .RomData(RomData), .Insn(Insn), .InsnValid(InsnValid),
      .InsnReady(InsnReady), .Jump(Jump), .JumpAddr(JumpAddr), .Ip(Ip), .Halted(Halted)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit bcd_ok(input logic [15:0] b);
      return (b[15:12] <= 4'd9) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   function automatic int pick_delay();
      return (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ROM responder: acks after cur_delay cycles of RomReq (0 = same cycle).
   assign RomAck  = RomReq && (age >= cur_delay);
   assign RomData = rom[RomAddr];

   always @(posedge Clk) begin
      if (RomReq && RomAck) begin
         age       <= 0;
         cur_delay <= pick_delay();
      end else if (RomReq) begin
         age <= age + 1;
      end else begin
         age       <= 0;
         cur_delay <= pick_delay();
      end
   end

   // Reference model: the decoder sees ROM words at consecutive decimal addresses; a jump
   // redirects the stream unless it is sampled while an instruction waits unconsumed.
   always @(negedge Clk) begin
      if (Rst) begin
         exp_ip = 0;
      end else begin
         if (Jump) assert (bcd_ok(JumpAddr)) else $error("illegal BCD digit in JumpAddr %h", JumpAddr);
         if (InsnValid && InsnReady) begin
            check("stream_insn", Insn, rom[int2bcd(exp_ip)]);
            xfers++;
            exp_ip = Jump ? bcd2int(JumpAddr) : (exp_ip + 1) % 10000;
         end else if (Jump && !InsnValid) begin
            exp_ip = bcd2int(JumpAddr);
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_dut();
      cyc();
      Rst = 1'b1; Run = 1'b0; InsnReady = 1'b0; Jump = 1'b0;
      cyc();
      cyc();
      Rst = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int unsigned n;
      n = 0;
      @(negedge Clk);
      while (!InsnValid && n < 20) begin
         @(negedge Clk);
         n++;
      end
      check(tag, InsnValid, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  cnt;
      bit  found;
      Rst = 1'b1; Run = 1'b0; InsnReady = 1'b0; Jump = 1'b0; JumpAddr = '0;
      for (int i = 0; i < 65536; i++) rom[i] = 4'($urandom_range(0, 15));
      rom[16'h0000] = 4'h3;
      rom[16'h9999] = 4'hA;
      rom[16'h0009] = 4'h5;

      // Reset values, then first fetch with combinational ack
      fixed_delay = 0;
      reset_dut();
      @(negedge Clk);
      check("rst_romreq", RomReq, 1'b0);
      check("rst_valid", InsnValid, 1'b0);
      check("rst_insn", Insn, 4'h0);
      check("rst_halted", Halted, 1'b1);
      check("rst_ip", Ip, 16'h0000);
      cyc();
      Run = 1'b1;
      @(negedge Clk);
      check("c0_romreq", RomReq, 1'b0);
      cyc();
      @(negedge Clk);
      check("c1_romreq", RomReq, 1'b1);
      check("c1_romaddr", RomAddr, 16'h0000);
      check("c1_halted", Halted, 1'b0);
      cyc();
      @(negedge Clk);
      check("c2_valid", InsnValid, 1'b1);
      check("c2_insn", Insn, 4'h3);
      check("c2_ip", Ip, 16'h0001);

      // Jump with transfer: next request goes to the target
      cyc();
      Jump = 1'b1; JumpAddr = 16'h0420; InsnReady = 1'b1;
      cyc();
      Jump = 1'b0; InsnReady = 1'b0;
      @(negedge Clk);
      check("jmp_romreq", RomReq, 1'b1);
      check("jmp_romaddr", RomAddr, 16'h0420);
      wait_valid("jmp_valid");
      check("jmp_insn", Insn, rom[16'h0420]);

      // BCD carry: 0009 -> 0010
      reset_dut();
      Jump = 1'b1; JumpAddr = 16'h0009;
      cyc();
      Jump = 1'b0;
      @(negedge Clk);
      check("idle_jump_ip", Ip, 16'h0009);
      cyc();
      Run = 1'b1;
      wait_valid("carry_valid");
      check("carry_insn", Insn, 4'h5);
      check("carry_ip", Ip, 16'h0010);

      // BCD wrap: 9999 -> 0000, stream continues at 0000
      reset_dut();
      Jump = 1'b1; JumpAddr = 16'h9999;
      cyc();
      Jump = 1'b0; Run = 1'b1;
      wait_valid("wrap_valid");
      check("wrap_insn", Insn, 4'hA);
      check("wrap_ip", Ip, 16'h0000);
      cyc();
      InsnReady = 1'b1;
      repeat (6) cyc();

      // Jump during REQ with ack delayed 3 cycles: word discarded, refetch at target
      fixed_delay = 3;
      reset_dut();
      Run = 1'b1; InsnReady = 1'b1;
      cyc();
      @(negedge Clk);
      check("flush_req", RomReq, 1'b1);
      cyc();
      Jump = 1'b1; JumpAddr = 16'h0357;
      cyc();
      Jump = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge Clk);
         check("flush_novalid", InsnValid, 1'b0);
         if (RomReq && RomAddr == 16'h0357) found = 1'b1;
         else cyc();
      end
      check("flush_readdr", found, 1'b1);
      wait_valid("flush_valid");
      check("flush_insn", Insn, rom[16'h0357]);

      // Run dropped mid-REQ, ack after 2 cycles: instruction held, then halt
      fixed_delay = 2;
      reset_dut();
      Run = 1'b1; InsnReady = 1'b0;
      cyc();
      @(negedge Clk);
      check("halt_req", RomReq, 1'b1);
      cyc();
      Run = 1'b0;
      wait_valid("halt_valid");
      check("halt_insn", Insn, 4'h3);
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge Clk);
         check("halt_held", InsnValid, 1'b1);
         check("halt_noreq", RomReq, 1'b0);
      end
      cyc();
      InsnReady = 1'b1;
      cyc();
      InsnReady = 1'b0;
      @(negedge Clk);
      check("halt_halted", Halted, 1'b1);
      check("halt_romreq", RomReq, 1'b0);
      check("halt_novalid", InsnValid, 1'b0);

      // Issue rate with combinational ack and ready tied high
      fixed_delay = 0;
      reset_dut();
      Run = 1'b1; InsnReady = 1'b1;
      wait_valid("rate_valid");
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         @(negedge Clk);
         cnt += int'(InsnValid);
      end
`ifdef INSN_PREFETCH_EN
      check("rate_valid_cycles", cnt, 20);
      cyc();
      Rst = 1'b1;
      cyc();
      Rst = 1'b0; Run = 1'b0; InsnReady = 1'b0;
      @(negedge Clk);
      check("midrst_romreq", RomReq, 1'b0);
      check("midrst_valid", InsnValid, 1'b0);
      check("midrst_insn", Insn, 4'h0);
      check("midrst_halted", Halted, 1'b1);
      check("midrst_ip", Ip, 16'h0000);
`else
      check("rate_valid_cycles", cnt, 10);
`endif

      // Randomized run against the stream model
      fixed_delay = -1;
      reset_dut();
      xfers = 0;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         Run = ($urandom_range(0, 7) != 0);
         if (InsnValid && $urandom_range(0, 9) == 0) begin
            Jump = 1'b1;
            JumpAddr = int2bcd(int'($urandom_range(0, 9999)));
            InsnReady = 1'b1;
         end else begin
            Jump = 1'b0;
            InsnReady = ($urandom_range(0, 1) == 1);
         end
      end
      cyc();
      Run = 1'b0; Jump = 1'b0; InsnReady = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge Clk);
         if (Halted && !InsnValid && !RomReq) found = 1'b1;
         else cyc();
      end
      check("rand_final_halt", found, 1'b1);
      check("rand_progress", (xfers >= 200), 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Instruction fetch stage. Sits directly upstream of the 4-bit-to-16-line one-hot instruction decoder.
- Holds a decimal (BCD) instruction pointer, modelled on dekatron counters, and reads 4-bit instructions from program ROM over a req/ack handshake.
- Presents one registered instruction at a time, with valid/ready, to the decoder/sequencer.
- Supports an IP load (jump) from the sequencer and a Run/Halt control.

Parameters:
- IP_DIGITS, 4, number of BCD digits in the IP; address width is IP_DIGITS*4.
- INSN_WIDTH, 4, instruction width; fixed by the decoder input.
- RESET_IP, 0, IP value loaded on reset, BCD encoded.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous reset, active-high.
- Run  in  1  enable fetching; deassert to halt.
- RomAddr  out  IP_DIGITS*4  BCD address to ROM; equals Ip while RomReq is high.
- RomReq  out  1  ROM read request.
- RomAck  in  1  ROM data valid; may assert in the same cycle as RomReq.
- RomData  in  INSN_WIDTH  ROM read data; sampled when RomReq & RomAck.
- Insn  out  INSN_WIDTH  registered instruction to the decoder.
- InsnValid  out  1  Insn is valid.
- InsnReady  in  1  sequencer consumes Insn; transfer = InsnValid & InsnReady.
- Jump  in  1  load IP from JumpAddr; qualified as defined under Behaviour.
- JumpAddr  in  IP_DIGITS*4  BCD jump target; digits greater than 9 are illegal.
- Ip  out  IP_DIGITS*4  address of the current or next fetched instruction.
- Halted  out  1  fetch idle with Run low.

Behaviour:
- Reset (synchronous, takes priority over all other inputs):
  - Ip=RESET_IP; RomReq=0; InsnValid=0; Insn=0; Halted=1; state IDLE.
  - Reset mid-transaction drops RomReq the next cycle; any late RomAck is ignored.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: Halted=1. If Run=1, go to REQ next cycle and set Halted=0.
  - REQ: RomReq=1, RomAddr=Ip.
    - On RomAck: capture RomData into Insn, set InsnValid=1, increment Ip in BCD, go to HOLD.
    - RomReq stays high until the ack.
  - HOLD: InsnValid=1, Insn stable.
    - On transfer: InsnValid=0. Go to REQ if Run=1, else IDLE.
- Latency:
  - Ack in the same cycle as req: Insn is valid the cycle after the ack edge.
  - Minimum issue interval without prefetch: 2 cycles per instruction.
- BCD increment:
  - Each digit counts 0..9; carry ripples between digits.
  - 9..9 wraps to 0..0 with no flag.
- Jump, when Jump is sampled with transfer in HOLD:
  - Ip=JumpAddr instead of the incremented value.
  - The next fetch reads JumpAddr.
- Jump at any other time:
  - IDLE: Ip=JumpAddr immediately.
  - REQ: set a pending-flush flag and store JumpAddr. Complete the handshake, discard the data (InsnValid stays 0), set Ip=JumpAddr, reissue REQ.
  - HOLD without transfer: ignored; the sequencer must hold Jump until the transfer.
- Run deasserted:
  - An outstanding REQ completes and the instruction is held in HOLD.
  - IDLE is entered after consumption.
  - The decoder never sees a torn instruction.
- An illegal BCD digit in JumpAddr is loaded as is. Behaviour is undefined; the bench asserts the digit is never above 9.

Optional Feature:
- Macro: INSN_PREFETCH_EN.
- Defined:
  - Adds a one-entry prefetch buffer. While in HOLD with Run=1, the next ROM read is issued.
  - On transfer, the buffer moves to Insn in the same edge, so InsnValid stays high: one instruction per cycle when ROM acks combinationally.
  - Jump or Rst flushes the buffer. An in-flight prefetch is discarded via the pending-flush flag.
- Undefined: no buffer; timing exactly as above.

Decomposition:
- Shared package dpc_fetch_pkg holds:
  - the FSM state enum;
  - IP_DIGITS/INSN_WIDTH defaults;
  - a BCD digit typedef;
  - the constant BCD_MAX_DIGIT=9.
- One natural sub-module: bcd_incrementer, combinational N-digit BCD +1 with wrap, reused later for the data-pointer counter.

Test Plan:
- Reset then Run=1, ROM[0000]=4'h3 with combinational ack -> RomReq in cycle 1, Insn=3 and InsnValid=1 in cycle 2, Ip=0001.
- Ip=0009 fetch -> Ip=0010; Ip=9999 fetch -> Ip=0000 (wrap, no stall).
- Jump=1, JumpAddr=0420 with transfer -> next RomAddr=0420, no instruction from 0001 is presented.
- Jump during REQ with ack delayed 3 cycles -> the returned word is discarded, InsnValid stays 0, the next request goes to JumpAddr.
- Run dropped mid-REQ with ack after 2 cycles -> Insn is held valid until InsnReady, then Halted=1 with RomReq=0.
- INSN_PREFETCH_EN, InsnReady tied 1, ROM acks combinationally -> InsnValid continuously 1, Insn follows ROM[0..n] one per cycle; Rst asserted mid-stream -> all outputs at reset values the next cycle.
